timer_input_register: RTL

TIMER_INPUT_REGISTER -- requirements
Module: timer_input_register

---
 rtl/timer_input_register.sv | 135 +++++++++++++
 1 files changed

// File: rtl/timer_input_register.sv
// Keypad time-entry register for a microwave timer: synchronizes and debounces
// the keypad strobe, then shifts accepted BCD digits into an MM:SS display.
module timer_input_register #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] saida_cod,
    input  logic       loadn,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [2:0] digit_count,
    output logic       entry_full,
    output logic       key_accepted,
    output logic       time_valid
);

    typedef enum logic {
        ARMED,
        HELD
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic       loadn_meta_q;
    logic       loadn_s_q;
    logic [3:0] cod_meta_q;
    logic [3:0] cod_s_q;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [3:0] min_tens_q;
    logic [3:0] min_units_q;
    logic [3:0] sec_tens_q;
    logic [3:0] sec_units_q;
    logic [2:0] digit_count_q;
    logic       key_accepted_q;

    logic       digit_ok;

    // Two-flop synchronizers; loadn idles high so reset parks it released.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadn_meta_q <= 1'b1;
            loadn_s_q    <= 1'b1;
            cod_meta_q   <= 4'd0;
            cod_s_q      <= 4'd0;
        end else begin
            loadn_meta_q <= loadn;
            loadn_s_q    <= loadn_meta_q;
            cod_meta_q   <= saida_cod;
            cod_s_q      <= cod_meta_q;
        end
    end

    assign digit_ok = (cod_s_q <= 4'd9) && (digit_count_q < 3'd4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARMED;
            cnt_q          <= 4'd0;
            min_tens_q     <= 4'd0;
            min_units_q    <= 4'd0;
            sec_tens_q     <= 4'd0;
            sec_units_q    <= 4'd0;
            digit_count_q  <= 3'd0;
            key_accepted_q <= 1'b0;
        end else begin
            key_accepted_q <= 1'b0;
            case (state_q)
                ARMED: begin
                    if (!loadn_s_q && enable) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= 4'd0;
                            state_q <= HELD;
                            // Invalid codes and a full entry still consume the press.
                            if (digit_ok && !clear) begin
                                min_tens_q     <= min_units_q;
                                min_units_q    <= sec_tens_q;
                                sec_tens_q     <= sec_units_q;
                                sec_units_q    <= cod_s_q;
                                digit_count_q  <= digit_count_q + 3'd1;
                                key_accepted_q <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
                HELD: begin
                    // Release detection deliberately ignores enable.
                    if (loadn_s_q) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= 4'd0;
                            state_q <= ARMED;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
                default: begin
                    state_q <= ARMED;
                    cnt_q   <= 4'd0;
                end
            endcase

            if (clear) begin
                min_tens_q    <= 4'd0;
                min_units_q   <= 4'd0;
                sec_tens_q    <= 4'd0;
                sec_units_q   <= 4'd0;
                digit_count_q <= 3'd0;
            end
        end
    end

    assign min_tens     = min_tens_q;
    assign min_units    = min_units_q;
    assign sec_tens     = sec_tens_q;
    assign sec_units    = sec_units_q;
    assign digit_count  = digit_count_q;
    assign key_accepted = key_accepted_q;
    assign entry_full   = (digit_count_q == 3'd4);
    assign time_valid   = (|{min_tens_q, min_units_q, sec_tens_q, sec_units_q})
                          && (sec_tens_q <= 4'd5);

endmodule
